// File: rtl/tick_sched.sv
// Multi-channel periodic event scheduler: per-channel tick counters post events that are
// granted round-robin to one registered valid/ready port. Optional one-shot: TICK_SCHED_ONESHOT_EN.
module tick_sched #(
  parameter int NCH = 4,
  parameter int PW  = 8,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           tick,
  input  logic           cfg_we,
  input  logic [IDW-1:0] cfg_addr,
  input  logic [PW-1:0]  cfg_period,
  input  logic           cfg_en,
  input  logic           cfg_oneshot,
  output logic           ev_valid,
  output logic [IDW-1:0] ev_id,
  input  logic           ev_ready,
  output logic [NCH-1:0] ch_active,
  output logic [NCH-1:0] ev_overrun,
  input  logic           ovr_clr
);

  logic [PW-1:0]  period [NCH];
  logic [PW-1:0]  cnt    [NCH];
  logic [NCH-1:0] en;
  logic [NCH-1:0] pending;
  logic [IDW-1:0] rr_ptr;

  logic [NCH-1:0] wr_hit;
  logic [NCH-1:0] counting;
  logic [NCH-1:0] fire;
  logic [NCH-1:0] gnt;
  logic [NCH-1:0] ovr_set;
  logic           slot_free;
  logic           found;
  logic [IDW-1:0] sel;
  logic [IDW-1:0] rr_next;
  int             scan_idx;

`ifdef TICK_SCHED_ONESHOT_EN
  logic [NCH-1:0] oneshot;
`else
  logic           unused_oneshot;
  assign unused_oneshot = cfg_oneshot;
`endif

  assign ch_active = en;
  assign slot_free = !ev_valid || ev_ready;

  // Addresses at or beyond NCH match no channel, so such writes fall away naturally.
  always_comb begin
    wr_hit   = '0;
    counting = '0;
    fire     = '0;
    ovr_set  = '0;
    for (int i = 0; i < NCH; i++) begin
      wr_hit[i]   = cfg_we && (cfg_addr == IDW'(i));
      counting[i] = tick && en[i] && (period[i] != '0) && !wr_hit[i];
      fire[i]     = counting[i] && (cnt[i] == period[i] - 1'b1);
      ovr_set[i]  = fire[i] && pending[i] && !gnt[i];
    end
  end

  // Round-robin scan starting at rr_ptr; first pending channel wins.
  always_comb begin
    found    = 1'b0;
    sel      = '0;
    scan_idx = 0;
    for (int k = 0; k < NCH; k++) begin
      scan_idx = (int'(rr_ptr) + k) % NCH;
      if (!found && pending[scan_idx]) begin
        found = 1'b1;
        sel   = IDW'(scan_idx);
      end
    end
    gnt = '0;
    if (slot_free && found) begin
      gnt[sel] = 1'b1;
    end
    rr_next = IDW'((int'(sel) + 1) % NCH);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin
        cnt[i]    <= '0;
        period[i] <= '0;
      end
      en         <= '0;
      pending    <= '0;
      ev_overrun <= '0;
      rr_ptr     <= '0;
      ev_valid   <= 1'b0;
      ev_id      <= '0;
`ifdef TICK_SCHED_ONESHOT_EN
      oneshot    <= '0;
`endif
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (wr_hit[i]) begin
          period[i]  <= cfg_period;
          en[i]      <= cfg_en;
          cnt[i]     <= '0;
          pending[i] <= 1'b0;
`ifdef TICK_SCHED_ONESHOT_EN
          oneshot[i] <= cfg_oneshot;
`endif
        end else begin
          if (counting[i]) begin
            cnt[i] <= fire[i] ? '0 : cnt[i] + 1'b1;
          end
          // A fire coinciding with a grant re-arms the bit for the next event.
          if (fire[i]) begin
            pending[i] <= 1'b1;
          end else if (gnt[i]) begin
            pending[i] <= 1'b0;
          end
`ifdef TICK_SCHED_ONESHOT_EN
          if (fire[i] && oneshot[i]) begin
            en[i] <= 1'b0;
          end
`endif
        end
        ev_overrun[i] <= ovr_set[i] || (ev_overrun[i] && !ovr_clr);
      end

      if (slot_free) begin
        ev_valid <= found;
        if (found) begin
          ev_id  <= sel;
          rr_ptr <= rr_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_tick_sched.sv
// Directed self-checking bench for tick_sched; one task per scenario.
module tb_tick_sched;

  localparam int NCH = 4;
  localparam int PW  = 8;
  localparam int IDW = 2;

  logic           clk;
  logic           reset;
  logic           tick;
  logic           cfg_we;
  logic [IDW-1:0] cfg_addr;
  logic [PW-1:0]  cfg_period;
  logic           cfg_en;
  logic           cfg_oneshot;
  logic           ev_valid;
  logic [IDW-1:0] ev_id;
  logic           ev_ready;
  logic [NCH-1:0] ch_active;
  logic [NCH-1:0] ev_overrun;
  logic           ovr_clr;

  int n_checks;
  int n_pass;

  tick_sched #(.NCH(NCH), .PW(PW), .IDW(IDW)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_period (cfg_period),
    .cfg_en     (cfg_en),
    .cfg_oneshot(cfg_oneshot),
    .ev_valid   (ev_valid),
    .ev_id      (ev_id),
    .ev_ready   (ev_ready),
    .ch_active  (ch_active),
    .ev_overrun (ev_overrun),
    .ovr_clr    (ovr_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [IDW-1:0] a, input logic [PW-1:0] p, input logic e, input logic os);
    cfg_we      = 1'b1;
    cfg_addr    = a;
    cfg_period  = p;
    cfg_en      = e;
    cfg_oneshot = os;
    step();
    cfg_we      = 1'b0;
    cfg_oneshot = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; tick = 1'b1;
    cfg_we = 1'b1; cfg_addr = 0; cfg_period = 8'd1; cfg_en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if (ev_valid !== 1'b0) $display("FAIL reset_valid c%0d: got %b want 0", c, ev_valid); else n_pass++;
      n_checks++;
      if (ch_active !== 4'b0000) $display("FAIL reset_active c%0d: got %b want 0000", c, ch_active); else n_pass++;
      n_checks++;
      if (ev_overrun !== 4'b0000) $display("FAIL reset_overrun c%0d: got %b want 0000", c, ev_overrun); else n_pass++;
    end
    tick = 1'b0; cfg_we = 1'b0; reset = 1'b1;
    step();
  endtask

  task automatic test_periodic();
    int   events;
    logic exp_v;
    events = 0;
    ev_ready = 1'b1;
    cfg(0, 8'd3, 1'b1, 1'b0);
    for (int n = 1; n <= 9; n++) begin
      tick = 1'b1; step(); tick = 1'b0; step();
      exp_v = (n % 3 == 0);
      if (ev_valid === 1'b1) events++;
      n_checks++;
      if (ev_valid !== exp_v) $display("FAIL periodic_valid tick%0d: got %b want %b", n, ev_valid, exp_v); else n_pass++;
      if (n % 3 == 0) begin
        n_checks++;
        if (ev_id !== 2'd0) $display("FAIL periodic_id tick%0d: got %0d want 0", n, ev_id); else n_pass++;
      end
    end
    n_checks++;
    if (events !== 3) $display("FAIL periodic_count: got %0d want 3", events); else n_pass++;
    cfg(0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic test_round_robin();
    do_reset();
    ev_ready = 1'b1;
    for (int c = 0; c < 4; c++) cfg(IDW'(c), 8'd1, 1'b1, 1'b0);
    for (int r = 0; r < 2; r++) begin
      tick = 1'b1; step(); tick = 1'b0;
      for (int k = 0; k < 4; k++) begin
        step();
        n_checks++;
        if (ev_valid !== 1'b1 || ev_id !== IDW'(k))
          $display("FAIL rr_seq r%0d k%0d: got v=%b id=%0d want v=1 id=%0d", r, k, ev_valid, ev_id, k);
        else n_pass++;
      end
      step();
      n_checks++;
      if (ev_valid !== 1'b0) $display("FAIL rr_drain r%0d: got %b want 0", r, ev_valid); else n_pass++;
    end
  endtask

  task automatic test_overrun();
    do_reset();
    ev_ready = 1'b0;
    cfg(2, 8'd1, 1'b1, 1'b0);
    tick = 1'b1; step(); tick = 1'b0; step();
    n_checks++;
    if (ev_valid !== 1'b1 || ev_id !== 2'd2) $display("FAIL ovr_first: got v=%b id=%0d want v=1 id=2", ev_valid, ev_id); else n_pass++;
    tick = 1'b1; step();
    n_checks++;
    if (ev_overrun !== 4'b0000) $display("FAIL ovr_early: got %b want 0000", ev_overrun); else n_pass++;
    step(); tick = 1'b0;
    n_checks++;
    if (ev_overrun !== 4'b0100) $display("FAIL ovr_set: got %b want 0100", ev_overrun); else n_pass++;
    n_checks++;
    if (ev_valid !== 1'b1 || ev_id !== 2'd2) $display("FAIL ovr_hold: got v=%b id=%0d want v=1 id=2", ev_valid, ev_id); else n_pass++;
    ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
    n_checks++;
    if (ev_overrun !== 4'b0000) $display("FAIL ovr_clr: got %b want 0000", ev_overrun); else n_pass++;
    ev_ready = 1'b1; step();
    n_checks++;
    if (ev_valid !== 1'b1 || ev_id !== 2'd2) $display("FAIL ovr_queued: got v=%b id=%0d want v=1 id=2", ev_valid, ev_id); else n_pass++;
    step();
    n_checks++;
    if (ev_valid !== 1'b0) $display("FAIL ovr_drain: got %b want 0", ev_valid); else n_pass++;
  endtask

  task automatic test_cfg_collision();
    logic exp_v;
    do_reset();
    ev_ready = 1'b1;
    cfg(1, 8'd3, 1'b1, 1'b0);
    for (int n = 0; n < 2; n++) begin
      tick = 1'b1; step(); tick = 1'b0; step();
    end
    cfg_we = 1'b1; cfg_addr = 2'd1; cfg_period = 8'd3; cfg_en = 1'b1; tick = 1'b1;
    step();
    cfg_we = 1'b0; tick = 1'b0;
    step();
    n_checks++;
    if (ev_valid !== 1'b0) $display("FAIL coll_nofire: got %b want 0", ev_valid); else n_pass++;
    for (int n = 1; n <= 3; n++) begin
      tick = 1'b1; step(); tick = 1'b0; step();
      exp_v = (n == 3);
      n_checks++;
      if (ev_valid !== exp_v || (exp_v && ev_id !== 2'd1))
        $display("FAIL coll_refire tick%0d: got v=%b id=%0d want v=%b id=1", n, ev_valid, ev_id, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_period_zero();
    do_reset();
    ev_ready = 1'b1;
    cfg(0, 8'd0, 1'b1, 1'b0);
    n_checks++;
    if (ch_active !== 4'b0001) $display("FAIL zero_active: got %b want 0001", ch_active); else n_pass++;
    for (int n = 1; n <= 5; n++) begin
      tick = 1'b1; step(); tick = 1'b0; step();
      n_checks++;
      if (ev_valid !== 1'b0) $display("FAIL zero_nofire tick%0d: got %b want 0", n, ev_valid); else n_pass++;
    end
  endtask

  task automatic test_oneshot();
    logic exp_v;
    logic exp_act;
    do_reset();
    ev_ready = 1'b1;
    cfg(3, 8'd2, 1'b1, 1'b1);
    for (int n = 1; n <= 6; n++) begin
      tick = 1'b1; step(); tick = 1'b0; step();
`ifdef TICK_SCHED_ONESHOT_EN
      exp_v = (n == 2);
`else
      exp_v = (n % 2 == 0);
`endif
      n_checks++;
      if (ev_valid !== exp_v || (exp_v && ev_id !== 2'd3))
        $display("FAIL oneshot tick%0d: got v=%b id=%0d want v=%b id=3", n, ev_valid, ev_id, exp_v);
      else n_pass++;
    end
`ifdef TICK_SCHED_ONESHOT_EN
    exp_act = 1'b0;
`else
    exp_act = 1'b1;
`endif
    n_checks++;
    if (ch_active[3] !== exp_act) $display("FAIL oneshot_active: got %b want %b", ch_active[3], exp_act); else n_pass++;
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    reset = 1'b0; tick = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_period = '0;
    cfg_en = 1'b0; cfg_oneshot = 1'b0; ev_ready = 1'b0; ovr_clr = 1'b0;
    test_reset();
    test_periodic();
    test_round_robin();
    test_overrun();
    test_cfg_collision();
    test_period_zero();
    test_oneshot();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
